// File: rtl/spike_addr_tx_if.sv
// Spike-address stream interface: valid/ready handshake carrying one
// source address per accepted beat from spike_addr_tx to the synapse units.
interface spike_addr_tx_if #(
  parameter int ADDR_BITS = 12
) ();
  logic                 src_valid;
  logic                 src_ready;
  logic [ADDR_BITS-1:0] src_addr;

  modport master (output src_valid, output src_addr, input src_ready);
  modport slave  (input src_valid, input src_addr, output src_ready);
endinterface

// File: rtl/spike_addr_tx.sv
// spike_addr_tx: captures a neuron group's spike vector at each timestep end,
// streams the address of every spiking neuron (ascending index) over a
// valid/ready handshake, then pulses ts_done to close the timestep.
// Optional feature macro: SPIKE_COUNT_EN adds spike_count and last_beat outputs.
module spike_addr_tx #(
  parameter int                   NUM_NEURONS = 16,
  parameter int                   ADDR_BITS   = 12,
  parameter logic [ADDR_BITS-1:0] IDLE_ADDR   = {ADDR_BITS{1'b1}}
) (
  input  logic                   CLK_Tx,
  input  logic                   RST_Tx,
  input  logic [ADDR_BITS-1:0]   base_addr,
  input  logic [NUM_NEURONS-1:0] spikes_in,
  input  logic                   ts_end,
  spike_addr_tx_if.master        src,
  output logic                   ts_done,
  output logic                   busy,
  output logic                   overrun
`ifdef SPIKE_COUNT_EN
  ,
  output logic [$clog2(NUM_NEURONS+1)-1:0] spike_count,
  output logic                             last_beat
`endif
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [NUM_NEURONS-1:0] pend_reg, pend_next;
  logic [ADDR_BITS-1:0]   base_reg, base_next;
  logic [ADDR_BITS-1:0]   addr_reg, addr_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic                   valid_reg, valid_next;
  logic                   overrun_reg, overrun_next;

  logic [NUM_NEURONS-1:0] idx_mask;
  logic [NUM_NEURONS-1:0] rem;
  logic [IDX_W-1:0]       low_pend, low_rem;
  logic                   any_pend, any_rem;
  logic                   accept;

  // Index of the lowest set bit; the loop walks downward so the last hit wins.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_NEURONS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // One-hot mask of the neuron currently on the bus, used to retire it.
  generate
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_mask
      assign idx_mask[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign rem      = pend_reg & ~idx_mask;
  assign low_pend = lowest_set(pend_reg);
  assign low_rem  = lowest_set(rem);
  assign any_pend = |pend_reg;
  assign any_rem  = |rem;
  assign accept   = valid_reg & src.src_ready;

  assign src.src_valid = valid_reg;
  assign src.src_addr  = addr_reg;
  assign ts_done       = (state_reg == DONE);
  assign busy          = (state_reg == LOAD) || (state_reg == SEND);
  assign overrun       = overrun_reg;

`ifdef SPIKE_COUNT_EN
  localparam int CNT_W = $clog2(NUM_NEURONS + 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_NEURONS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_NEURONS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Remaining-beat counter: loaded at capture, one less per accepted beat.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == IDLE && ts_end) cnt_next = popcount(spikes_in);
    else if (accept)                 cnt_next = cnt_reg - CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge CLK_Tx) begin
    if (RST_Tx) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  assign spike_count = cnt_reg;
  assign last_beat   = valid_reg && (cnt_reg == CNT_W'(1));
`endif

  // Next-state and datapath decisions for the capture/serialise sequence.
  always_comb begin
    state_next   = state_reg;
    pend_next    = pend_reg;
    base_next    = base_reg;
    addr_next    = addr_reg;
    idx_next     = idx_reg;
    valid_next   = valid_reg;
    // Any ts_end outside IDLE (DONE included) is lost and flagged.
    overrun_next = overrun_reg | (ts_end && (state_reg != IDLE));
    case (state_reg)
      IDLE: begin
        if (ts_end) begin
          pend_next  = spikes_in;
          base_next  = base_addr;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (!any_pend) begin
          state_next = DONE;
        end else begin
          idx_next   = low_pend;
          addr_next  = base_reg + ADDR_BITS'(low_pend);
          valid_next = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          pend_next = rem;
          if (any_rem) begin
            idx_next  = low_rem;
            addr_next = base_reg + ADDR_BITS'(low_rem);
          end else begin
            valid_next = 1'b0;
            addr_next  = IDLE_ADDR;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything, dropping any frame.
  always_ff @(posedge CLK_Tx) begin
    if (RST_Tx) begin
      state_reg   <= IDLE;
      pend_reg    <= '0;
      base_reg    <= '0;
      addr_reg    <= IDLE_ADDR;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pend_reg    <= pend_next;
      base_reg    <= base_next;
      addr_reg    <= addr_next;
      idx_reg     <= idx_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

endmodule

// File: tb/tb_spike_addr_tx.sv
// Self-checking bench for spike_addr_tx: expected addresses are queued when a
// frame is launched and popped as the DUT hands each beat over.
module tb_spike_addr_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] base_addr;
  logic [15:0] spikes_in;
  logic        ts_end;
  logic        ts_done, busy, overrun;
`ifdef SPIKE_COUNT_EN
  logic [4:0]  spike_count;
  logic        last_beat;
`endif

  spike_addr_tx_if #(.ADDR_BITS(12)) src_if ();

  spike_addr_tx #(.NUM_NEURONS(16), .ADDR_BITS(12)) dut (
    .CLK_Tx    (clk),
    .RST_Tx    (rst),
    .base_addr (base_addr),
    .spikes_in (spikes_in),
    .ts_end    (ts_end),
    .src       (src_if.master),
    .ts_done   (ts_done),
    .busy      (busy),
    .overrun   (overrun)
`ifdef SPIKE_COUNT_EN
    ,
    .spike_count (spike_count),
    .last_beat   (last_beat)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one frame and follow it to ts_done.
  task automatic run_frame(input logic [15:0] spk, input logic [11:0] base,
                           input int stall, input int ovr_at, input logic [15:0] ovr_spk);
    int n, nexp, beats, exp_done;
    bit done, seen;
    logic [11:0] a;
    nexp = 0;
    for (int i = 0; i < 16; i++) begin
      if (spk[i]) begin
        a = base + 12'(i);
        exp_q.push_back(a);
        nexp++;
      end
    end
    exp_done = nexp + 2 + ((nexp > 0) ? stall : 0);
    spikes_in = spk;
    base_addr = base;
    ts_end    = 1'b1;
    @(posedge clk); #1;
    ts_end    = 1'b0;
    spikes_in = 16'($urandom);
    base_addr = 12'($urandom);
    n = 1; beats = 0; done = 0; seen = 0;
    while (!done && n < 60) begin
      src_if.src_ready = !(n >= 2 && n < 2 + stall);
      if (n == ovr_at) begin
        ts_end    = 1'b1;
        spikes_in = ovr_spk;
      end else begin
        ts_end = 1'b0;
      end
      @(negedge clk);
      if (src_if.src_valid) begin
        if (!seen) begin
          chk("first_lat", n, 2);
          seen = 1;
        end
`ifdef SPIKE_COUNT_EN
        chk("spike_count", spike_count, exp_q.size());
        chk("last_beat", last_beat, exp_q.size() == 1);
`endif
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else if (src_if.src_ready) begin
          a = exp_q.pop_front();
          chk("addr", src_if.src_addr, a);
          beats++;
        end else begin
          chk("stall_addr", src_if.src_addr, exp_q[0]);
        end
      end
      if (ts_done) begin
        done = 1;
        chk("done_lat", n, exp_done);
        chk("q_empty", exp_q.size(), 0);
        chk("busy_at_done", busy, 0);
`ifdef SPIKE_COUNT_EN
        chk("count_at_done", spike_count, 0);
`endif
      end else begin
        chk("busy", busy, 1);
      end
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk("timeout", 0, 1);
    ts_end = 1'b0;
    src_if.src_ready = 1'b1;
    chk("beats", beats, nexp);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", ts_done, 0);
    chk("idle_valid", src_if.src_valid, 0);
    chk("idle_addr", src_if.src_addr, 12'hFFF);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; ts_end = 1'b0; spikes_in = '0; base_addr = '0;
    src_if.src_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", src_if.src_valid, 0);
    chk("rst_addr", src_if.src_addr, 12'hFFF);
    chk("rst_busy", busy, 0);
    chk("rst_done", ts_done, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk); #1;

    // Basic three-spike frame, then an empty frame.
    run_frame(16'h0013, 12'd8, 0, 0, 16'h0);
    run_frame(16'h0000, 12'd0, 0, 0, 16'h0);
    // Stalled first beat and address wrap.
    run_frame(16'h8001, 12'hFF8, 3, 0, 16'h0);
    chk("no_overrun", overrun, 0);
    // Second ts_end during SEND must be ignored and flagged.
    run_frame(16'h0F00, 12'h200, 0, 3, 16'h00FF);
    chk("overrun", overrun, 1);

    // Reset in the middle of SEND drops the frame.
    spikes_in = 16'h00F0; base_addr = 12'h010; ts_end = 1'b1;
    @(posedge clk); #1;
    ts_end = 1'b0; src_if.src_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_valid", src_if.src_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    src_if.src_ready = 1'b1;
    @(negedge clk);
    chk("mrst_valid", src_if.src_valid, 0);
    chk("mrst_addr", src_if.src_addr, 12'hFFF);
    chk("mrst_busy", busy, 0);
    chk("mrst_overrun", overrun, 0);
    for (int k = 0; k < 4; k++) begin
      chk("mrst_no_done", ts_done, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // All sixteen neurons fire: 18 cycles from ts_end to ts_done.
    run_frame(16'hFFFF, 12'h100, 0, 0, 16'h0);
    // A few random frames with full throughput or short stalls.
    for (int r = 0; r < 4; r++) begin
      run_frame(16'($urandom), 12'($urandom), r, 0, 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
